calc_engine: RTL and testbench

- Arithmetic/entry stage directly downstream of the keypad scanner → debouncer → edge-trigger chain.
- Consumes one-cycle key strobes plus 4-bit keycodes and maintains two 3-digit decimal operands and a pending operator.
- Computes +, −, × and drives three BCD digits to the char_7seg display drivers, replacing the plain digit shift register.
- Binary→BCD conversion is sequential (shift-add-3), so results appear several cycles after "=".

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/calc_engine_bin2bcd_seq.sv | 75 +++++++
 rtl/calc_engine.sv | 182 ++++++++++++++++++
 tb/tb_calc_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry/arithmetic stage.
//   calc_state_e : top-level entry/conversion states
//   calc_op_e    : pending arithmetic operator
//   KEY_*        : special keycodes coming from the keypad chain
//   key_to_op()  : maps an operator keycode to its calc_op_e value
package calc_pkg;

    typedef enum logic [2:0] {
        StEntryA,
        StOpWait,
        StEntryB,
        StConvert,
        StResult,
        StError
    } calc_state_e;

    typedef enum logic [1:0] {
        OpNone,
        OpAdd,
        OpSub,
        OpMul
    } calc_op_e;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam int unsigned MAXVAL    = 999;
    localparam logic [3:0]  ERR_DIGIT = 4'hE;

    function automatic calc_op_e key_to_op(input logic [3:0] key);
        calc_op_e op;
        case (key)
            KEY_ADD: op = OpAdd;
            KEY_SUB: op = OpSub;
            KEY_MUL: op = OpMul;
            default: op = OpNone;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_engine_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// A start pulse loads bin_i; BINW shift cycles follow and done_o pulses for one
// cycle once the three BCD digits are final. Digits hold until the next start.
//   clock, resetn          : clock and synchronous active-low reset
//   start_i, bin_i         : load request and binary value (must be <= 999)
//   done_o                 : one-cycle completion pulse
//   bcd1_o/bcd10_o/bcd100_o: ones/tens/hundreds digits
module bin2bcd_seq #(
    parameter int unsigned BINW = 10
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start_i,
    input  logic [BINW-1:0] bin_i,
    output logic            done_o,
    output logic [3:0]      bcd1_o,
    output logic [3:0]      bcd10_o,
    output logic [3:0]      bcd100_o
);

    localparam int unsigned CntW = $clog2(BINW + 1);

    logic [BINW-1:0] bin_q, bin_d;
    logic [11:0]     bcd_q, bcd_d;
    logic [11:0]     adj;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    always_comb begin
        // Add-3 correction on any digit >= 5 before the shift
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CntW'(BINW);
        end else if (cnt_q != '0) begin
            // Input is bounded to 999, so the top bit of adj is always zero
            bcd_d  = {adj[10:0], bin_q[BINW-1]};
            bin_d  = {bin_q[BINW-2:0], 1'b0};
            cnt_d  = cnt_q - CntW'(1);
            done_d = (cnt_q == CntW'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o   = done_q;
    assign bcd1_o   = bcd_q[3:0];
    assign bcd10_o  = bcd_q[7:4];
    assign bcd100_o = bcd_q[11:8];

endmodule

// File: rtl/calc_engine.sv
// Three-digit decimal calculator stage fed by debounced key strobes.
// Keeps two operands (binary for arithmetic, BCD display shifted directly during
// entry), a pending operator, and converts results to BCD sequentially.
//   clock, resetn            : clock and synchronous active-low reset
//   keycode, keystrobe       : key code sampled on a one-cycle strobe
//   bcd1, bcd10, bcd100      : registered display digits (ones/tens/hundreds)
//   busy                     : result conversion in progress, keys dropped
//   error                    : overflow or negative result latched until clear
module calc_engine
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BINW   = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] keycode,
    input  logic       keystrobe,
    output logic [3:0] bcd1,
    output logic [3:0] bcd10,
    output logic [3:0] bcd100,
    output logic       busy,
    output logic       error
);

    localparam int unsigned WideW = 2 * BINW;

    calc_state_e            state_q, state_d;
    logic [BINW-1:0]        a_q, a_d;
    logic [BINW-1:0]        b_q, b_d;
    calc_op_e               op_q, op_d;
    logic                   chain_q, chain_d;
    logic [DIGITS-1:0][3:0] disp_q, disp_d;

    logic [WideW-1:0] a_wide, b_wide, res_wide;
    logic             res_bad;
    logic             is_digit, is_op;
    logic             conv_start, conv_done;
    logic [3:0]       conv1, conv10, conv100;

    assign is_digit = (keycode <= 4'd9);
    assign is_op    = (key_to_op(keycode) != OpNone);

    // Evaluate A op B at full product width so overflow is detectable
    always_comb begin
        a_wide = WideW'(a_q);
        b_wide = WideW'(b_q);
        case (op_q)
            OpAdd:   res_wide = a_wide + b_wide;
            OpSub:   res_wide = a_wide - b_wide;
            OpMul:   res_wide = a_wide * b_wide;
            default: res_wide = a_wide;
        endcase
        res_bad = (res_wide > WideW'(MAXVAL)) || ((op_q == OpSub) && (b_q > a_q));
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        chain_d    = chain_q;
        disp_d     = disp_q;
        conv_start = 1'b0;

        if (keystrobe && (keycode == KEY_CLR) && (state_q != StConvert)) begin
            state_d = StEntryA;
            a_d     = '0;
            b_d     = '0;
            op_d    = OpNone;
            chain_d = 1'b0;
            disp_d  = '0;
        end else begin
            case (state_q)
                StEntryA: begin
                    if (keystrobe && is_digit) begin
                        if (a_q < BINW'(100)) begin
                            a_d    = a_q * BINW'(10) + BINW'(keycode);
                            disp_d = {disp_q[DIGITS-2:0], keycode};
                        end
                    end else if (keystrobe && is_op) begin
                        op_d    = key_to_op(keycode);
                        state_d = StOpWait;
                    end
                end
                StOpWait: begin
                    if (keystrobe && is_digit) begin
                        b_d       = BINW'(keycode);
                        disp_d    = '0;
                        disp_d[0] = keycode;
                        state_d   = StEntryB;
                    end else if (keystrobe && is_op) begin
                        op_d = key_to_op(keycode);
                    end
                end
                StEntryB: begin
                    if (keystrobe && is_digit) begin
                        if (b_q < BINW'(100)) begin
                            b_d    = b_q * BINW'(10) + BINW'(keycode);
                            disp_d = {disp_q[DIGITS-2:0], keycode};
                        end
                    end else if (keystrobe && (is_op || (keycode == KEY_EQ))) begin
                        if (res_bad) begin
                            state_d = StError;
                            disp_d  = {DIGITS{ERR_DIGIT}};
                        end else begin
                            // Result is final here; A takes it now, display waits for BCD
                            conv_start = 1'b1;
                            a_d        = res_wide[BINW-1:0];
                            chain_d    = is_op;
                            if (is_op) begin
                                op_d = key_to_op(keycode);
                            end
                            state_d = StConvert;
                        end
                    end
                end
                StConvert: begin
                    if (conv_done) begin
                        disp_d    = '0;
                        disp_d[0] = conv1;
                        disp_d[1] = conv10;
                        disp_d[2] = conv100;
                        state_d   = chain_q ? StOpWait : StResult;
                        chain_d   = 1'b0;
                    end
                end
                StResult: begin
                    if (keystrobe && is_digit) begin
                        a_d       = BINW'(keycode);
                        disp_d    = '0;
                        disp_d[0] = keycode;
                        state_d   = StEntryA;
                    end else if (keystrobe && is_op) begin
                        op_d    = key_to_op(keycode);
                        state_d = StOpWait;
                    end
                end
                StError: ;
                default: state_d = StEntryA;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StEntryA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OpNone;
            chain_q <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            chain_q <= chain_d;
            disp_q  <= disp_d;
        end
    end

    bin2bcd_seq #(
        .BINW (BINW)
    ) u_bin2bcd (
        .clock    (clock),
        .resetn   (resetn),
        .start_i  (conv_start),
        .bin_i    (res_wide[BINW-1:0]),
        .done_o   (conv_done),
        .bcd1_o   (conv1),
        .bcd10_o  (conv10),
        .bcd100_o (conv100)
    );

    assign bcd1   = disp_q[0];
    assign bcd10  = disp_q[1];
    assign bcd100 = disp_q[2];
    assign busy   = (state_q == StConvert);
    assign error  = (state_q == StError);

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: directed key sequences plus random key
// traffic, compared every cycle against a decimal-arithmetic calculator model.
module tb_calc_engine;

    localparam int BINW = 10;

    logic       clock;
    logic       resetn;
    logic [3:0] keycode;
    logic       keystrobe;
    logic [3:0] bcd1, bcd10, bcd100;
    logic       busy, error;

    calc_engine #(
        .DIGITS (3),
        .BINW   (BINW)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .keycode   (keycode),
        .keystrobe (keystrobe),
        .bcd1      (bcd1),
        .bcd10     (bcd10),
        .bcd100    (bcd100),
        .busy      (busy),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Calculator model: modes 0=entering A, 1=waiting for B, 2=entering B,
    // 3=converting, 4=showing result, 5=error
    int m_mode, m_a, m_b, m_op, m_disp, m_res, m_left;
    bit m_err, m_chain;

    function automatic void model_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_op = 0; m_disp = 0;
        m_res = 0; m_left = 0; m_err = 0; m_chain = 0;
    endfunction

    function automatic int key_op(int k);
        if (k == 10) return 1;
        if (k == 11) return 2;
        if (k == 12) return 3;
        return 0;
    endfunction

    function automatic void model_key(int k);
        int r;
        if (m_left > 0) return;
        if (k == 13) begin
            model_reset();
            return;
        end
        if (m_err) return;
        case (m_mode)
            0: begin
                if (k <= 9) begin
                    if (m_a < 100) m_a = m_a * 10 + k;
                    m_disp = m_a;
                end else if (key_op(k) != 0) begin
                    m_op = key_op(k); m_mode = 1;
                end
            end
            1: begin
                if (k <= 9) begin
                    m_b = k; m_disp = k; m_mode = 2;
                end else if (key_op(k) != 0) begin
                    m_op = key_op(k);
                end
            end
            2: begin
                if (k <= 9) begin
                    if (m_b < 100) m_b = m_b * 10 + k;
                    m_disp = m_b;
                end else if (k == 15 || key_op(k) != 0) begin
                    if (m_op == 1) r = m_a + m_b;
                    else if (m_op == 2) r = m_a - m_b;
                    else r = m_a * m_b;
                    if (r > 999 || r < 0) begin
                        m_err = 1; m_mode = 5;
                    end else begin
                        m_res = r; m_a = r;
                        m_chain = (key_op(k) != 0);
                        if (m_chain) m_op = key_op(k);
                        m_left = BINW + 2;
                        m_mode = 3;
                    end
                end
            end
            4: begin
                if (k <= 9) begin
                    m_a = k; m_disp = k; m_mode = 0;
                end else if (key_op(k) != 0) begin
                    m_op = key_op(k); m_mode = 1;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [11:0] exp_disp();
        if (m_err) return 12'hEEE;
        return {4'(m_disp / 100), 4'((m_disp / 10) % 10), 4'(m_disp % 10)};
    endfunction

    task automatic check(input string tag);
        logic [11:0] got, exp;
        logic        exp_busy;
        got      = {bcd100, bcd10, bcd1};
        exp      = exp_disp();
        exp_busy = (m_left > 0);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s display: got %h expected %h", tag, got, exp);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
        end
        checks++;
        assert (error === m_err) else begin
            errors++;
            $error("FAIL %s error: got %b expected %b", tag, error, m_err);
        end
    endtask

    task automatic check_val(input string tag, input logic [11:0] want);
        logic [11:0] got;
        got = {bcd100, bcd10, bcd1};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Advance one clock and compare at the falling edge
    task automatic cycle(input string tag);
        @(negedge clock);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_disp = m_res;
                m_mode = m_chain ? 1 : 4;
                m_chain = 0;
            end
        end
        check(tag);
    endtask

    task automatic settle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic press(input logic [3:0] k, input string tag);
        keycode   = k;
        keystrobe = 1'b1;
        @(posedge clock);
        #1;
        keystrobe = 1'b0;
        keycode   = 4'($urandom);
        model_key(int'(k));
        cycle(tag);
    endtask

    task automatic pulse_reset(input string tag);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        model_reset();
        cycle(tag);
    endtask

    initial begin
        resetn    = 1'b0;
        keystrobe = 1'b0;
        keycode   = 4'h0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset");
        resetn = 1'b1;

        // 12 + 34
        press(4'h1, "add_a1"); check_val("add_a1_val", 12'h001);
        press(4'h2, "add_a2"); check_val("add_a2_val", 12'h012);
        press(4'hA, "add_op"); check_val("add_op_val", 12'h012);
        press(4'h3, "add_b1"); check_val("add_b1_val", 12'h003);
        press(4'h4, "add_b2"); check_val("add_b2_val", 12'h034);
        press(4'hF, "add_eq");
        settle(12, "add_conv");
        check_val("add_res", 12'h046);

        // fourth digit ignored
        press(4'hD, "clr1");
        press(4'h1, "ent1"); press(4'h2, "ent2"); press(4'h3, "ent3"); press(4'h4, "ent4");
        check_val("ent_max3", 12'h123);

        // 25 * 4
        press(4'hD, "clr2");
        press(4'h2, "mul_a1"); press(4'h5, "mul_a2"); press(4'hC, "mul_op");
        press(4'h4, "mul_b"); press(4'hF, "mul_eq");
        settle(12, "mul_conv");
        check_val("mul_res", 12'h100);

        // chaining 9 * 9 * 9
        press(4'hD, "clr3");
        press(4'h9, "ch_a"); press(4'hC, "ch_op1"); press(4'h9, "ch_b1"); press(4'hC, "ch_op2");
        settle(12, "ch_conv1");
        check_val("ch_mid", 12'h081);
        press(4'h9, "ch_b2"); check_val("ch_b2_val", 12'h009);
        press(4'hF, "ch_eq");
        settle(12, "ch_conv2");
        check_val("ch_res", 12'h729);

        // overflow 999 + 1
        press(4'hD, "clr4");
        press(4'h9, "ov1"); press(4'h9, "ov2"); press(4'h9, "ov3");
        press(4'hA, "ov_op"); press(4'h1, "ov_b"); press(4'hF, "ov_eq");
        check_val("ov_eee", 12'hEEE);
        settle(12, "ov_hold");
        press(4'h5, "ov_digit");
        press(4'hD, "ov_clr");
        check_val("ov_cleared", 12'h000);

        // negative 5 - 7, then 7 - 7
        press(4'h5, "neg_a"); press(4'hB, "neg_op"); press(4'h7, "neg_b"); press(4'hF, "neg_eq");
        press(4'hD, "clr5");
        press(4'h7, "z_a"); press(4'hB, "z_op"); press(4'h7, "z_b"); press(4'hF, "z_eq");
        settle(12, "z_conv");
        check_val("z_res", 12'h000);

        // key during busy is dropped
        press(4'hD, "clr6");
        press(4'h2, "bz_a"); press(4'hA, "bz_op"); press(4'h3, "bz_b"); press(4'hF, "bz_eq");
        settle(3, "bz_wait");
        press(4'h3, "bz_drop");
        press(4'hD, "bz_clr_drop");
        settle(12, "bz_conv");
        check_val("bz_res", 12'h005);

        // reset mid-conversion
        press(4'hD, "clr7");
        press(4'h9, "rc_a"); press(4'hC, "rc_op"); press(4'h9, "rc_b"); press(4'hF, "rc_eq");
        settle(4, "rc_wait");
        pulse_reset("rc_reset");
        settle(15, "rc_after");
        check_val("rc_res", 12'h000);

        // random key traffic
        for (int i = 0; i < 400; i++) begin
            press(4'($urandom_range(0, 15)), "rand_key");
            settle(int'($urandom_range(0, 13)), "rand_idle");
        end
        settle(14, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
